spi_slave_regif: RTL and testbench

- SPI mode-0 responder: the far end of our SPI master datapath on the same bus.
- Oversamples SCK/CS_N/MOSI in the system clock domain and decodes a 1-byte command (R/W bit + 7-bit address).
- Issues register-bus write/read strobes toward a local register bank and shifts read data back on MISO.
- Supports multi-byte bursts within one CS_N assertion.

---
 rtl/spi_slave_regif.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_regif.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder: oversampled SCK/CS_N/MOSI, {rw,addr} command byte, register-bus strobes, MISO readback.
// Build with SPI_SLAVE_ADDR_INC_EN defined to auto-increment the register address after every data byte.
module spi_slave_regif #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sck,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [DATA_W-1:0] i_reg_rdata,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CMD, RLOAD, RDATA, WDATA} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   oe_q, oe_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;

  logic              sck_s, cs_n_s, mosi_s;
  logic              sck_rise, sck_fall, cs_fall, byte_done;
  logic [DATA_W-1:0] rx_byte;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign cs_fall   = ~cs_n_s & cs_prev_q;
  assign byte_done = sck_rise && (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign rx_byte   = {rx_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
    end
  end

  // A read request waits one cycle in CMD/RDATA so RLOAD lands when i_reg_rdata is valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD: begin
        if (re_q) state_d = RLOAD;
        else if (byte_done && !rx_byte[DATA_W-1]) state_d = WDATA;
      end
      RLOAD:   state_d = RDATA;
      RDATA:   if (re_q) state_d = RLOAD;
      WDATA:   state_d = WDATA;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && cs_n_s) state_d = IDLE;
  end

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_n_s;
    rx_d        = sck_rise ? rx_byte : rx_q;
    bit_cnt_d   = bit_cnt_q;
    if (cs_n_s)        bit_cnt_d = '0;
    else if (byte_done) bit_cnt_d = '0;
    else if (sck_rise) bit_cnt_d = bit_cnt_q + CNT_W'(1);

    tx_d    = tx_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    case (state_q)
      CMD: begin
        if (byte_done) begin
          addr_d = rx_byte[ADDR_W-1:0];
          re_d   = rx_byte[DATA_W-1];
        end
      end
      RLOAD: begin
        tx_d = i_reg_rdata;
        oe_d = 1'b1;
      end
      RDATA: begin
        // The fall at count 0 follows a byte boundary; the reload already presents the new MSB.
        if (sck_fall && bit_cnt_q != '0) tx_d = {tx_q[DATA_W-2:0], 1'b0};
        if (byte_done) begin
          re_d = 1'b1;
`ifdef SPI_SLAVE_ADDR_INC_EN
          addr_d = addr_q + ADDR_W'(1);
`endif
        end
      end
      WDATA: begin
        if (byte_done) begin
          we_d    = 1'b1;
          wdata_d = rx_byte;
        end
      end
      default: ;
    endcase
`ifdef SPI_SLAVE_ADDR_INC_EN
    if (we_q) addr_d = addr_q + ADDR_W'(1);
`endif
    if (state_d == IDLE) begin
      tx_d = '0;
      oe_d = 1'b0;
    end
  end

  always_comb begin
    o_busy      = (state_q != IDLE);
    o_miso      = tx_q[DATA_W-1];
    o_miso_oe   = oe_q;
    o_reg_addr  = addr_q;
    o_reg_wdata = wdata_q;
    o_reg_we    = we_q;
    o_reg_re    = re_q;
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed SPI frames against spi_slave_regif with a strobe/MISO scoreboard and a behavioural register bank.
module tb_spi_slave_regif;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst_n, sck, cs_n, mosi;
  logic              miso, miso_oe, reg_we, reg_re, busy;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata = '0;
  logic [DATA_W-1:0] mem [0:127];

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t               exp_q[$];
  logic [DATA_W-1:0] exp_miso_q[$];
  logic [DATA_W-1:0] obs_miso_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                oe_hi_cnt = 0;
  int                oe_mark;

  always #5 clk = ~clk;

  spi_slave_regif #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
    .o_reg_we(reg_we), .o_reg_re(reg_re), .i_reg_rdata(reg_rdata), .o_busy(busy)
  );

  // Register bank: read data valid exactly one cycle after the read strobe.
  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (miso_oe === 1'b1) oe_hi_cnt++;
      if (rst_n && (reg_we || reg_re)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL strobe_unexpected: got we=%0b re=%0b addr=0x%0h wdata=0x%0h, required no strobe",
                   reg_we, reg_re, reg_addr, reg_wdata);
        end else begin
          e = exp_q.pop_front();
          if (reg_we !== e.we || reg_re !== !e.we || reg_addr !== e.addr ||
              (e.we && reg_wdata !== e.data)) begin
            n_err++;
            $display("FAIL strobe: got we=%0b re=%0b addr=0x%0h wdata=0x%0h, required we=%0b addr=0x%0h wdata=0x%0h",
                     reg_we, reg_re, reg_addr, reg_wdata, e.we, e.addr, e.data);
          end
        end
      end
      while (obs_miso_q.size() != 0) begin
        logic [DATA_W-1:0] got;
        got = obs_miso_q.pop_front();
        n_cmp++;
        if (exp_miso_q.size() == 0) begin
          n_err++;
          $display("FAIL miso_unexpected: got 0x%0h, required no byte", got);
        end else if (got !== exp_miso_q[0]) begin
          n_err++;
          $display("FAIL miso_byte: got 0x%0h, required 0x%0h", got, exp_miso_q[0]);
          void'(exp_miso_q.pop_front());
        end else begin
          void'(exp_miso_q.pop_front());
        end
      end
    end
  endtask

  task automatic push_ev(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    ev_t e;
    e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cs_low(input int half);
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Mode 0 master: data set after the fall, sampled by both sides on the rise.
  task automatic spi_xfer(input logic [DATA_W-1:0] tx, input int nbits, input int half, input bit chk);
    logic [DATA_W-1:0] rx;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[DATA_W-1-i];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      rx  = {rx[DATA_W-2:0], miso};
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
    if (chk) obs_miso_q.push_back(rx);
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = DATA_W'(8'h40 + i);
    mem[3] = 8'h3C; mem[0] = 8'h01; mem[1] = 8'h02;
    fork
      monitor();
    join_none
    #1;
    check("reset_outputs", {busy, miso_oe, miso, reg_we, reg_re, reg_addr, reg_wdata}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during bit 3 of a write data byte.
    cs_low(4);
    spi_xfer(8'h05, 8, 4, 1'b0);
    spi_xfer(8'hFF, 3, 4, 1'b0);
    check("busy_mid_write", busy, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_burst", {busy, miso_oe, miso, reg_we, reg_re, reg_addr, reg_wdata}, '0);
    cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single write after reset.
    oe_mark = oe_hi_cnt;
    push_ev(1'b1, 7'h05, 8'hA5);
    cs_low(4);
    spi_xfer(8'h05, 8, 4, 1'b0);
    spi_xfer(8'hA5, 8, 5, 1'b0);
    cs_high();
    check("write_oe_cycles", oe_hi_cnt - oe_mark, 0);

    // Single read of address 3.
    push_ev(1'b0, 7'h03, 8'h00);
`ifdef SPI_SLAVE_ADDR_INC_EN
    push_ev(1'b0, 7'h04, 8'h00);
`else
    push_ev(1'b0, 7'h03, 8'h00);
`endif
    exp_miso_q.push_back(8'h3C);
    cs_low(4);
    spi_xfer(8'h83, 8, 6, 1'b0);
    spi_xfer(8'h00, 8, 6, 1'b1);
    repeat (2) @(negedge clk);
    check("read_oe_held", miso_oe, 1);
    cs_n = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    check("read_oe_released", {miso_oe, miso}, 0);
    cs_high();

    // Write burst across the address wrap.
    push_ev(1'b1, 7'h7F, 8'h11);
`ifdef SPI_SLAVE_ADDR_INC_EN
    push_ev(1'b1, 7'h00, 8'h22);
`else
    push_ev(1'b1, 7'h7F, 8'h22);
`endif
    cs_low(4);
    spi_xfer(8'h7F, 8, 4, 1'b0);
    spi_xfer(8'h11, 8, 4, 1'b0);
    spi_xfer(8'h22, 8, 4, 1'b0);
    cs_high();

    // Abort after 5 bits of a data byte.
    cs_low(4);
    spi_xfer(8'h05, 8, 4, 1'b0);
    spi_xfer(8'hC3, 5, 4, 1'b0);
    cs_n = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_oe", miso_oe, 0);
    cs_high();

    // Read burst at minimum SCK period.
    push_ev(1'b0, 7'h00, 8'h00);
`ifdef SPI_SLAVE_ADDR_INC_EN
    push_ev(1'b0, 7'h01, 8'h00);
    push_ev(1'b0, 7'h02, 8'h00);
    exp_miso_q.push_back(8'h01);
    exp_miso_q.push_back(8'h02);
`else
    push_ev(1'b0, 7'h00, 8'h00);
    push_ev(1'b0, 7'h00, 8'h00);
    exp_miso_q.push_back(8'h01);
    exp_miso_q.push_back(8'h01);
`endif
    cs_low(4);
    spi_xfer(8'h80, 8, 4, 1'b0);
    spi_xfer(8'h00, 8, 4, 1'b1);
    spi_xfer(8'h00, 8, 4, 1'b1);
    cs_high();

    repeat (10) @(negedge clk);
    check("strobes_outstanding", exp_q.size(), 0);
    check("miso_outstanding", exp_miso_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
